// File: rtl/tpu_job_sequencer.sv
// Job sequencer driving the tpuv1 MMIO port: A rows, B rows, optional C init, start, wait, C readback.
// Optional job cycle counter enabled by defining TPU_SEQ_PERF_EN.
module tpu_job_sequencer #(
    parameter int DIM         = 8,
    parameter int DATAW       = 64,
    parameter int ADDRW       = 16,
    parameter int WAIT_CYCLES = 3*DIM-1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic             cmd_accum,
    output logic             cmd_ready,
    input  logic             in_valid,
    input  logic [DATAW-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data,
    input  logic             out_ready,
    output logic             done,
    output logic [31:0]      perf_cycles,
    output logic [ADDRW-1:0] tpu_addr,
    output logic             tpu_rw,
    output logic [DATAW-1:0] tpu_wdata,
    input  logic [DATAW-1:0] tpu_rdata
);

    localparam int IDXW = $clog2(2*DIM);
    localparam int CNTW = $clog2(WAIT_CYCLES+2);

    localparam logic [ADDRW-1:0] A_BASE     = ADDRW'(16'h0100);
    localparam logic [ADDRW-1:0] B_BASE     = ADDRW'(16'h0200);
    localparam logic [ADDRW-1:0] C_BASE     = ADDRW'(16'h0300);
    localparam logic [ADDRW-1:0] START_ADDR = ADDRW'(16'h0400);
    localparam logic [IDXW-1:0]  LAST_AB    = IDXW'(DIM-1);
    localparam logic [IDXW-1:0]  LAST_C     = IDXW'(2*DIM-1);
    localparam logic [CNTW-1:0]  WAIT_LOAD  = CNTW'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LD_A  = 3'd1,
        S_LD_B  = 3'd2,
        S_LD_C  = 3'd3,
        S_START = 3'd4,
        S_WAIT  = 3'd5,
        S_RD_C  = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [CNTW-1:0]  wcnt_q, wcnt_d;
    logic             accum_q, accum_d;
    logic [ADDRW-1:0] tpu_addr_q, tpu_addr_d;
    logic             tpu_rw_q, tpu_rw_d;
    logic [DATAW-1:0] tpu_wdata_q, tpu_wdata_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;

    logic             cmd_hs_s;
    logic             in_hs_s;
    logic             out_hs_s;
    logic [ADDRW-1:0] ld_base_s;
    logic [IDXW-1:0]  ld_last_s;
    state_t           ld_next_s;

    function automatic logic [ADDRW-1:0] word_addr(input logic [ADDRW-1:0] base,
                                                   input logic [IDXW-1:0]  idx);
        return base + (ADDRW'(idx) << 3);
    endfunction

    assign cmd_hs_s = cmd_valid && cmd_ready_q;
    assign in_hs_s  = in_valid && in_ready_q;
    assign out_hs_s = out_valid_q && out_ready;

    // Per-load-state base address, last index and successor
    always_comb begin
        ld_base_s = '0;
        ld_last_s = '0;
        ld_next_s = S_IDLE;
        case (state_q)
            S_LD_A: begin
                ld_base_s = A_BASE;
                ld_last_s = LAST_AB;
                ld_next_s = S_LD_B;
            end
            S_LD_B: begin
                ld_base_s = B_BASE;
                ld_last_s = LAST_AB;
                ld_next_s = accum_q ? S_START : S_LD_C;
            end
            S_LD_C: begin
                ld_base_s = C_BASE;
                ld_last_s = LAST_C;
                ld_next_s = S_START;
            end
            default: begin
                ld_base_s = '0;
                ld_last_s = '0;
                ld_next_s = S_IDLE;
            end
        endcase
    end

    // Next-state and next registered-output logic; tpu outputs idle (addr 0, read) unless set below
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        accum_d     = accum_q;
        tpu_addr_d  = '0;
        tpu_rw_d    = 1'b0;
        tpu_wdata_d = '0;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_hs_s) begin
                    accum_d = cmd_accum;
                    idx_d   = '0;
                    state_d = S_LD_A;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LD_A, S_LD_B, S_LD_C: begin
                // one write per accepted word only: tpuv1 shifts memB on every write
                if (in_hs_s) begin
                    tpu_rw_d    = 1'b1;
                    tpu_addr_d  = word_addr(ld_base_s, idx_q);
                    tpu_wdata_d = in_data;
                    if (idx_q == ld_last_s) begin
                        idx_d   = '0;
                        state_d = ld_next_s;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            S_START: begin
                tpu_rw_d   = 1'b1;
                tpu_addr_d = START_ADDR;
                wcnt_d     = WAIT_LOAD;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    idx_d      = '0;
                    tpu_addr_d = C_BASE;
                    state_d    = S_RD_C;
                end else begin
                    wcnt_d = wcnt_q - CNTW'(1);
                end
            end
            S_RD_C: begin
                if (out_hs_s) begin
                    if (idx_q == LAST_C) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d      = idx_q + IDXW'(1);
                        tpu_addr_d = word_addr(C_BASE, idx_q + IDXW'(1));
                    end
                end else begin
                    tpu_addr_d = word_addr(C_BASE, idx_q);
                end
            end
            default: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        cmd_ready_d = (state_d == S_IDLE);
        in_ready_d  = (state_d == S_LD_A) || (state_d == S_LD_B) || (state_d == S_LD_C);
        out_valid_d = (state_d == S_RD_C);
    end

    // State and registered-output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            wcnt_q      <= '0;
            accum_q     <= 1'b0;
            tpu_addr_q  <= '0;
            tpu_rw_q    <= 1'b0;
            tpu_wdata_q <= '0;
            cmd_ready_q <= 1'b1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            accum_q     <= accum_d;
            tpu_addr_q  <= tpu_addr_d;
            tpu_rw_q    <= tpu_rw_d;
            tpu_wdata_q <= tpu_wdata_d;
            cmd_ready_q <= cmd_ready_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

`ifdef TPU_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Job cycle counter: cleared on accept, counts busy cycles, saturates
    always_comb begin
        if (cmd_hs_s) begin
            perf_d = 32'd0;
        end else if ((state_q != S_IDLE) && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end else begin
            perf_d = perf_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

    assign cmd_ready = cmd_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = tpu_rdata;
    assign done      = done_q;
    assign tpu_addr  = tpu_addr_q;
    assign tpu_rw    = tpu_rw_q;
    assign tpu_wdata = tpu_wdata_q;

endmodule
